// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control slice: ALUOp codes, RV32 opcode
// and funct7 constants, sequencer state encoding and op class predicates.
package alu_pkg;

    localparam int unsigned ALU_CODE_W = 5;
    typedef logic [ALU_CODE_W-1:0] aluop_t;

    localparam aluop_t ALU_ADD    = 5'd0;
    localparam aluop_t ALU_SUB    = 5'd1;
    localparam aluop_t ALU_XOR    = 5'd2;
    localparam aluop_t ALU_OR     = 5'd3;
    localparam aluop_t ALU_AND    = 5'd4;
    localparam aluop_t ALU_SLL    = 5'd5;
    localparam aluop_t ALU_SRL    = 5'd6;
    localparam aluop_t ALU_MUL    = 5'd7;
    localparam aluop_t ALU_DIV    = 5'd8;
    localparam aluop_t ALU_SRA    = 5'd9;
    localparam aluop_t ALU_SLT    = 5'd10;
    localparam aluop_t ALU_SLTU   = 5'd11;
    localparam aluop_t ALU_MULH   = 5'd12;
    localparam aluop_t ALU_MULHSU = 5'd13;
    localparam aluop_t ALU_MULHU  = 5'd14;
    localparam aluop_t ALU_DIVU   = 5'd15;
    localparam aluop_t ALU_REM    = 5'd16;
    localparam aluop_t ALU_REMU   = 5'd17;
    localparam aluop_t ALU_NA     = 5'd31;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_mul_class(input aluop_t op);
        return (op == ALU_MUL) || (op == ALU_MULH) ||
               (op == ALU_MULHSU) || (op == ALU_MULHU);
    endfunction

    function automatic logic is_div_class(input aluop_t op);
        return (op == ALU_DIV) || (op == ALU_DIVU) ||
               (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Purely combinational RV32I(+M) instruction field to ALUOp decode.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int unsigned ENABLE_M = 1
) (
    input  logic       alu_control_i,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output aluop_t     aluop_o
);

    localparam bit M_EN = (ENABLE_M != 0);

    // Map opcode/funct3/funct7 to an ALU operation; anything unrecognised is NA.
    always_comb begin
        aluop_o = ALU_NA;
        if (alu_control_i) begin
            aluop_o = ALU_ADD;
        end else begin
            case (opcode_i)
                OPC_OP: begin
                    if (funct7_i == F7_BASE) begin
                        case (funct3_i)
                            3'b000:  aluop_o = ALU_ADD;
                            3'b001:  aluop_o = ALU_SLL;
                            3'b010:  aluop_o = ALU_SLT;
                            3'b011:  aluop_o = ALU_SLTU;
                            3'b100:  aluop_o = ALU_XOR;
                            3'b101:  aluop_o = ALU_SRL;
                            3'b110:  aluop_o = ALU_OR;
                            default: aluop_o = ALU_AND;
                        endcase
                    end else if (funct7_i == F7_ALT) begin
                        if (funct3_i == 3'b000) begin
                            aluop_o = ALU_SUB;
                        end else if (funct3_i == 3'b101) begin
                            aluop_o = ALU_SRA;
                        end
                    end else if ((funct7_i == F7_MULDIV) && M_EN) begin
                        case (funct3_i)
                            3'b000:  aluop_o = ALU_MUL;
                            3'b001:  aluop_o = ALU_MULH;
                            3'b010:  aluop_o = ALU_MULHSU;
                            3'b011:  aluop_o = ALU_MULHU;
                            3'b100:  aluop_o = ALU_DIV;
                            3'b101:  aluop_o = ALU_DIVU;
                            3'b110:  aluop_o = ALU_REM;
                            default: aluop_o = ALU_REMU;
                        endcase
                    end
                end
                OPC_OP_IMM: begin
                    case (funct3_i)
                        3'b000: aluop_o = ALU_ADD;
                        3'b010: aluop_o = ALU_SLT;
                        3'b011: aluop_o = ALU_SLTU;
                        3'b100: aluop_o = ALU_XOR;
                        3'b110: aluop_o = ALU_OR;
                        3'b111: aluop_o = ALU_AND;
                        3'b001: begin
                            if (funct7_i == F7_BASE) aluop_o = ALU_SLL;
                        end
                        default: begin
                            if (funct7_i == F7_BASE) begin
                                aluop_o = ALU_SRL;
                            end else if (funct7_i == F7_ALT) begin
                                aluop_o = ALU_SRA;
                            end
                        end
                    endcase
                end
                OPC_LOAD, OPC_STORE: begin
                    if (funct3_i == 3'b010) aluop_o = ALU_ADD;
                end
                OPC_BRANCH: begin
                    if ((funct3_i != 3'b010) && (funct3_i != 3'b011)) aluop_o = ALU_ADD;
                end
                OPC_JALR: begin
                    if (funct3_i == 3'b000) aluop_o = ALU_ADD;
                end
                OPC_JAL, OPC_LUI, OPC_AUIPC: aluop_o = ALU_ADD;
                default: aluop_o = ALU_NA;
            endcase
        end
    end

endmodule

// File: rtl/alu_control_seq.sv
// ALU control with a stall sequencer for multi-cycle MUL/DIV operations.
module alu_control_seq
    import alu_pkg::*;
#(
    parameter int unsigned ENABLE_M   = 1,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned ALUOP_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    input  logic               alu_control_i,
    input  logic [6:0]         opcode_i,
    input  logic [2:0]         funct3_i,
    input  logic [6:0]         funct7_i,
    output logic [ALUOP_W-1:0] aluop_o,
    output logic               illegal_o,
    output logic               stall_o,
    output logic               md_start_o,
    output logic               done_o
);

    localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC);
    // The start cycle and the final BUSY cycle (counter at zero) each account
    // for one stall cycle, hence the load value of CYCLES-2.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

    aluop_t           dec_op;
    aluop_t           op_q;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             multi;
    logic             start;

    alu_op_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_dec (
        .alu_control_i (alu_control_i),
        .opcode_i      (opcode_i),
        .funct3_i      (funct3_i),
        .funct7_i      (funct7_i),
        .aluop_o       (dec_op)
    );

    // Classify the decoded op and derive the start condition (IDLE only).
    always_comb begin
        multi = is_mul_class(dec_op) || is_div_class(dec_op);
        start = (state_q == ST_IDLE) && valid_i && multi;
    end

    // Sequencer state, stall counter and latched op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= ALU_NA;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_BUSY;
                        op_q    <= dec_op;
                        cnt_q   <= is_mul_class(dec_op) ? MUL_LOAD : DIV_LOAD;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Output drive: decode passes through in IDLE, latched op otherwise.
    always_comb begin
        md_start_o = start;
        stall_o    = start || (state_q == ST_BUSY);
        done_o     = (state_q == ST_DONE);
        illegal_o  = (state_q == ST_IDLE) && valid_i && (dec_op == ALU_NA);
        aluop_o    = (state_q == ST_IDLE) ? ALUOP_W'(dec_op) : ALUOP_W'(op_q);
    end

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: table-driven decode vectors plus
// hand-written multi-cycle sequences, checked through an expectation queue.
module tb_alu_control_seq;

    logic       clk = 1'b0;
    logic       rst, valid_i, alu_control_i;
    logic [6:0] opcode_i, funct7_i;
    logic [2:0] funct3_i;

    logic [4:0] aluop_o, n_aluop;
    logic       illegal_o, stall_o, md_start_o, done_o;
    logic       n_illegal, n_stall, n_start, n_done;

    always #5 clk = ~clk;

    alu_control_seq #(
        .ENABLE_M   (1),
        .MUL_CYCLES (4),
        .DIV_CYCLES (32),
        .ALUOP_W    (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_i       (valid_i),
        .alu_control_i (alu_control_i),
        .opcode_i      (opcode_i),
        .funct3_i      (funct3_i),
        .funct7_i      (funct7_i),
        .aluop_o       (aluop_o),
        .illegal_o     (illegal_o),
        .stall_o       (stall_o),
        .md_start_o    (md_start_o),
        .done_o        (done_o)
    );

    alu_control_seq #(
        .ENABLE_M   (0),
        .MUL_CYCLES (4),
        .DIV_CYCLES (32),
        .ALUOP_W    (5)
    ) dut_nom (
        .clk           (clk),
        .rst           (rst),
        .valid_i       (valid_i),
        .alu_control_i (alu_control_i),
        .opcode_i      (opcode_i),
        .funct3_i      (funct3_i),
        .funct7_i      (funct7_i),
        .aluop_o       (n_aluop),
        .illegal_o     (n_illegal),
        .stall_o       (n_stall),
        .md_start_o    (n_start),
        .done_o        (n_done)
    );

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] I  = 7'b0010011;
    localparam logic [6:0] F0 = 7'b0000000;
    localparam logic [6:0] FA = 7'b0100000;
    localparam logic [6:0] FM = 7'b0000001;

    typedef struct {
        string      tag;
        logic [4:0] aluop;
        logic       ill, stall, start, done;
        logic [4:0] n_aluop;
        logic       n_ill;
    } exp_t;

    typedef struct {
        string      tag;
        logic       valid, ac;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] aluop;
        logic       ill;
        logic [4:0] n_aluop;
        logic       n_ill;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    function automatic exp_t mkexp(string tag, logic [4:0] a, logic il, logic st,
                                   logic sp, logic dn, logic [4:0] na, logic nil);
        exp_t e;
        e.tag = tag; e.aluop = a; e.ill = il; e.stall = st; e.start = sp; e.done = dn;
        e.n_aluop = na; e.n_ill = nil;
        return e;
    endfunction

    function automatic vec_t mkv(string tag, logic v, logic ac, logic [6:0] opc, logic [2:0] f3,
                                 logic [6:0] f7, logic [4:0] a, logic il, logic [4:0] na, logic nil);
        vec_t t;
        t.tag = tag; t.valid = v; t.ac = ac; t.opc = opc; t.f3 = f3; t.f7 = f7;
        t.aluop = a; t.ill = il; t.n_aluop = na; t.n_ill = nil;
        return t;
    endfunction

    task automatic chk(string tag, string field, logic [4:0] act, logic [4:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, expected %0d (t=%0t)", tag, field, act, req, $time);
        end
    endtask

    // Pop the oldest expectation and compare it against both instances.
    task automatic compare_front();
        exp_t e;
        if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sbq.pop_front();
        chk(e.tag, "aluop",      aluop_o,    e.aluop);
        chk(e.tag, "illegal",    illegal_o,  e.ill);
        chk(e.tag, "stall",      stall_o,    e.stall);
        chk(e.tag, "md_start",   md_start_o, e.start);
        chk(e.tag, "done",       done_o,     e.done);
        chk(e.tag, "nom_aluop",  n_aluop,    e.n_aluop);
        chk(e.tag, "nom_ill",    n_illegal,  e.n_ill);
        chk(e.tag, "nom_stall",  n_stall,    1'b0);
        chk(e.tag, "nom_start",  n_start,    1'b0);
        chk(e.tag, "nom_done",   n_done,     1'b0);
    endtask

    // One clock: drive just after the rising edge, check at the falling edge.
    task automatic step(logic r, logic v, logic ac, logic [6:0] opc, logic [2:0] f3,
                        logic [6:0] f7, exp_t e);
        @(posedge clk);
        #1;
        rst = r; valid_i = v; alu_control_i = ac;
        opcode_i = opc; funct3_i = f3; funct7_i = f7;
        sbq.push_back(e);
        @(negedge clk);
        compare_front();
    endtask

    // Full multi-cycle op; a valid MUL is held on the inputs while busy/done
    // to show it is ignored until the sequencer returns to IDLE.
    task automatic run_mop(string tag, logic [2:0] f3, logic [4:0] code, int unsigned cyc);
        step(1'b0, 1'b1, 1'b0, R, f3, FM, mkexp({tag, "_start"}, code, 1'b0, 1'b1, 1'b1, 1'b0, 5'd31, 1'b1));
        for (int unsigned k = 1; k < cyc; k++)
            step(1'b0, 1'b1, 1'b0, R, 3'b000, FM, mkexp({tag, "_busy"}, code, 1'b0, 1'b1, 1'b0, 1'b0, 5'd31, 1'b1));
        step(1'b0, 1'b1, 1'b0, R, 3'b000, FM, mkexp({tag, "_done"}, code, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 1'b1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; valid_i = 1'b0; alu_control_i = 1'b0;
        opcode_i = '0; funct3_i = '0; funct7_i = '0;

        tbl.push_back(mkv("addi",      1, 0, I, 3'b000, 7'b1010101, 5'd0,  0, 5'd0,  0));
        tbl.push_back(mkv("sub",       1, 0, R, 3'b000, FA, 5'd1,  0, 5'd1,  0));
        tbl.push_back(mkv("srai",      1, 0, I, 3'b101, FA, 5'd9,  0, 5'd9,  0));
        tbl.push_back(mkv("add",       1, 0, R, 3'b000, F0, 5'd0,  0, 5'd0,  0));
        tbl.push_back(mkv("sll",       1, 0, R, 3'b001, F0, 5'd5,  0, 5'd5,  0));
        tbl.push_back(mkv("slt",       1, 0, R, 3'b010, F0, 5'd10, 0, 5'd10, 0));
        tbl.push_back(mkv("sltu",      1, 0, R, 3'b011, F0, 5'd11, 0, 5'd11, 0));
        tbl.push_back(mkv("xor",       1, 0, R, 3'b100, F0, 5'd2,  0, 5'd2,  0));
        tbl.push_back(mkv("srl",       1, 0, R, 3'b101, F0, 5'd6,  0, 5'd6,  0));
        tbl.push_back(mkv("or",        1, 0, R, 3'b110, F0, 5'd3,  0, 5'd3,  0));
        tbl.push_back(mkv("and",       1, 0, R, 3'b111, F0, 5'd4,  0, 5'd4,  0));
        tbl.push_back(mkv("sra",       1, 0, R, 3'b101, FA, 5'd9,  0, 5'd9,  0));
        tbl.push_back(mkv("r_alt_or",  1, 0, R, 3'b110, FA, 5'd31, 1, 5'd31, 1));
        tbl.push_back(mkv("r_f7bad",   1, 0, R, 3'b000, 7'b0000010, 5'd31, 1, 5'd31, 1));
        tbl.push_back(mkv("slli",      1, 0, I, 3'b001, F0, 5'd5,  0, 5'd5,  0));
        tbl.push_back(mkv("slli_alt",  1, 0, I, 3'b001, FA, 5'd31, 1, 5'd31, 1));
        tbl.push_back(mkv("srli",      1, 0, I, 3'b101, F0, 5'd6,  0, 5'd6,  0));
        tbl.push_back(mkv("srxi_bad",  1, 0, I, 3'b101, FM, 5'd31, 1, 5'd31, 1));
        tbl.push_back(mkv("slti",      1, 0, I, 3'b010, 7'b1111111, 5'd10, 0, 5'd10, 0));
        tbl.push_back(mkv("sltiu",     1, 0, I, 3'b011, F0, 5'd11, 0, 5'd11, 0));
        tbl.push_back(mkv("xori",      1, 0, I, 3'b100, F0, 5'd2,  0, 5'd2,  0));
        tbl.push_back(mkv("ori",       1, 0, I, 3'b110, F0, 5'd3,  0, 5'd3,  0));
        tbl.push_back(mkv("andi",      1, 0, I, 3'b111, F0, 5'd4,  0, 5'd4,  0));
        tbl.push_back(mkv("lw",        1, 0, 7'b0000011, 3'b010, F0, 5'd0,  0, 5'd0,  0));
        tbl.push_back(mkv("lb",        1, 0, 7'b0000011, 3'b000, F0, 5'd31, 1, 5'd31, 1));
        tbl.push_back(mkv("sw",        1, 0, 7'b0100011, 3'b010, F0, 5'd0,  0, 5'd0,  0));
        tbl.push_back(mkv("sb",        1, 0, 7'b0100011, 3'b000, F0, 5'd31, 1, 5'd31, 1));
        tbl.push_back(mkv("beq",       1, 0, 7'b1100011, 3'b000, F0, 5'd0,  0, 5'd0,  0));
        tbl.push_back(mkv("bne",       1, 0, 7'b1100011, 3'b001, F0, 5'd0,  0, 5'd0,  0));
        tbl.push_back(mkv("blt",       1, 0, 7'b1100011, 3'b100, F0, 5'd0,  0, 5'd0,  0));
        tbl.push_back(mkv("bge",       1, 0, 7'b1100011, 3'b101, F0, 5'd0,  0, 5'd0,  0));
        tbl.push_back(mkv("bltu",      1, 0, 7'b1100011, 3'b110, F0, 5'd0,  0, 5'd0,  0));
        tbl.push_back(mkv("bgeu",      1, 0, 7'b1100011, 3'b111, F0, 5'd0,  0, 5'd0,  0));
        tbl.push_back(mkv("b_f3_010",  1, 0, 7'b1100011, 3'b010, F0, 5'd31, 1, 5'd31, 1));
        tbl.push_back(mkv("jal",       1, 0, 7'b1101111, 3'b101, FA, 5'd0,  0, 5'd0,  0));
        tbl.push_back(mkv("jalr",      1, 0, 7'b1100111, 3'b000, F0, 5'd0,  0, 5'd0,  0));
        tbl.push_back(mkv("jalr_bad",  1, 0, 7'b1100111, 3'b001, F0, 5'd31, 1, 5'd31, 1));
        tbl.push_back(mkv("lui",       1, 0, 7'b0110111, 3'b011, F0, 5'd0,  0, 5'd0,  0));
        tbl.push_back(mkv("auipc",     1, 0, 7'b0010111, 3'b110, F0, 5'd0,  0, 5'd0,  0));
        tbl.push_back(mkv("opc_ff",    1, 0, 7'b1111111, 3'b000, F0, 5'd31, 1, 5'd31, 1));
        tbl.push_back(mkv("force_ff",  1, 1, 7'b1111111, 3'b000, F0, 5'd0,  0, 5'd0,  0));
        tbl.push_back(mkv("force_mul", 1, 1, R, 3'b000, FM, 5'd0,  0, 5'd0,  0));
        tbl.push_back(mkv("inv_ff",    0, 0, 7'b1111111, 3'b000, F0, 5'd31, 0, 5'd31, 0));
        tbl.push_back(mkv("inv_mul",   0, 0, R, 3'b000, FM, 5'd7,  0, 5'd31, 0));

        // Reset, then the first cycle out of reset follows the inputs.
        step(1'b1, 1'b0, 1'b0, 7'd0, 3'd0, 7'd0, mkexp("reset", 5'd31, 0, 0, 0, 0, 5'd31, 0));
        step(1'b0, 1'b1, 1'b0, I, 3'b000, F0, mkexp("post_rst", 5'd0, 0, 0, 0, 0, 5'd0, 0));

        foreach (tbl[i])
            step(1'b0, tbl[i].valid, tbl[i].ac, tbl[i].opc, tbl[i].f3, tbl[i].f7,
                 mkexp(tbl[i].tag, tbl[i].aluop, tbl[i].ill, 1'b0, 1'b0, 1'b0, tbl[i].n_aluop, tbl[i].n_ill));

        // All eight M ops back to back; each starts the cycle after DONE.
        run_mop("mul",    3'b000, 5'd7,  4);
        run_mop("mulh",   3'b001, 5'd12, 4);
        run_mop("mulhsu", 3'b010, 5'd13, 4);
        run_mop("mulhu",  3'b011, 5'd14, 4);
        run_mop("div",    3'b100, 5'd8,  32);
        run_mop("divu",   3'b101, 5'd15, 32);
        run_mop("rem",    3'b110, 5'd16, 32);
        run_mop("remu",   3'b111, 5'd17, 32);
        step(1'b0, 1'b0, 1'b0, 7'd0, 3'd0, 7'd0, mkexp("idle_after", 5'd31, 0, 0, 0, 0, 5'd31, 0));

        // Reset during BUSY aborts the divide without ever pulsing done.
        step(1'b0, 1'b1, 1'b0, R, 3'b100, FM, mkexp("divrst_start", 5'd8, 0, 1, 1, 0, 5'd31, 1));
        step(1'b0, 1'b0, 1'b0, 7'd0, 3'd0, 7'd0, mkexp("divrst_b1", 5'd8, 0, 1, 0, 0, 5'd31, 0));
        step(1'b0, 1'b0, 1'b0, 7'd0, 3'd0, 7'd0, mkexp("divrst_b2", 5'd8, 0, 1, 0, 0, 5'd31, 0));
        step(1'b1, 1'b0, 1'b0, 7'd0, 3'd0, 7'd0, mkexp("divrst_b3", 5'd8, 0, 1, 0, 0, 5'd31, 0));
        for (int unsigned k = 0; k < 40; k++)
            step(1'b0, 1'b0, 1'b0, 7'd0, 3'd0, 7'd0, mkexp("divrst_idle", 5'd31, 0, 0, 0, 0, 5'd31, 0));

        // A fresh op after the abort runs its full length.
        run_mop("mul_after_rst", 3'b000, 5'd7, 4);
        step(1'b0, 1'b1, 1'b0, R, 3'b000, FA, mkexp("sub_final", 5'd1, 0, 0, 0, 0, 5'd1, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
